// File: rtl/nibble_add_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial adder.
package nibble_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned nibbles_of(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder slice with carry in and carry out.
module nibble_add_slice
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(NIBBLE_W); i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder that reuses one nibble slice per cycle, LSB nibble first.
// Optional subtract mode (A - B) is enabled by defining NIBBLE_SERIAL_SUB_EN.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned NIBBLES = nibbles_of(WIDTH);
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_chk
      $error("nibble_serial_add_ctrl: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  state_e state, state_nxt;

  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             carry_q, carry_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             in_ready_nxt;
  logic             out_valid_nxt;
  logic             busy_nxt;

  logic                sub_c;
  logic [NIBBLE_W-1:0] nib_a_c;
  logic [NIBBLE_W-1:0] nib_b_c;
  logic [NIBBLE_W-1:0] nib_sum_c;
  logic                nib_cout_c;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign sub_c = in_sub;
`else
  assign sub_c = 1'b0;
`endif

  // Select the operand nibbles addressed by the pass index.
  always_comb begin
    nib_a_c = '0;
    nib_b_c = '0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        nib_a_c = a_q[n*NIBBLE_W +: NIBBLE_W];
        nib_b_c = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_add_slice u_slice (
    .a    (nib_a_c),
    .b    (nib_b_c),
    .cin  (carry_q),
    .sum  (nib_sum_c),
    .cout (nib_cout_c)
  );

  // State register and all datapath / output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      result_q  <= result_nxt;
      carry_q   <= carry_nxt;
      idx_q     <= idx_nxt;
      out_sum   <= sum_nxt;
      out_cout  <= cout_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state;
    a_nxt      = a_q;
    b_nxt      = b_q;
    result_nxt = result_q;
    carry_nxt  = carry_q;
    idx_nxt    = idx_q;
    sum_nxt    = out_sum;
    cout_nxt   = out_cout;

    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_nxt      = in_a;
          b_nxt      = sub_c ? ~in_b : in_b;
          carry_nxt  = sub_c;
          idx_nxt    = '0;
          result_nxt = '0;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) begin
            result_nxt[n*NIBBLE_W +: NIBBLE_W] = nib_sum_c;
          end
        end
        carry_nxt = nib_cout_c;
        if (idx_q == IDX_LAST) begin
          idx_nxt   = '0;
          sum_nxt   = result_nxt;
          cout_nxt  = nib_cout_c;
          state_nxt = ST_DONE;
        end else begin
          idx_nxt = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the upcoming state.
    in_ready_nxt  = (state_nxt == ST_IDLE);
    out_valid_nxt = (state_nxt == ST_DONE);
    busy_nxt      = (state_nxt != ST_IDLE);
  end

endmodule
